// File: rtl/pakout_router_pkg.sv
// Shared widths, FSM state types and the address-to-channel routing helper
// for the pakout_router family.
package pakout_router_pkg;

  localparam int NS_PACKET_SIZE  = 32;
  localparam int NS_ADDRESS_SIZE = 8;
  localparam int NS_DATA_SIZE    = 16;

  typedef enum logic {
    IN_IDLE,
    IN_WAIT
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE,
    O_REQ,
    O_REL
  } out_state_t;

  // Each outbound channel owns a contiguous block of span addresses.
  function automatic int route_idx(input int dst, input int span);
    return dst / span;
  endfunction

endpackage

// File: rtl/pakout_router_chnl.sv
// One outbound channel: DEPTH-entry packet buffer plus four-phase sender FSM.
// NS_PAKOUT_ROUTER_CNT_EN adds an 8-bit completed-handshake counter.
module pakout_router_chnl
  import pakout_router_pkg::*;
#(
  parameter int PSZ   = NS_PACKET_SIZE,
  parameter int DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_push,
  input  logic [PSZ-1:0] i_pkt,
  output logic           o_full,
  output logic           o_empty,
  output logic           o_req,
  input  logic           i_ack,
  output logic [PSZ-1:0] o_pakio
`ifdef NS_PAKOUT_ROUTER_CNT_EN
  ,
  output logic [7:0]     o_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [PSZ-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic [PSZ-1:0] r_pakio;
  out_state_t     r_state;
  out_state_t     w_next;
  logic           w_load;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_pop  = 1'b0;
    case (r_state)
      O_IDLE: if (!w_empty) begin
        w_load = 1'b1;
        w_next = O_REQ;
      end
      O_REQ: if (i_ack) begin
        w_pop  = 1'b1;
        w_next = O_REL;
      end
      O_REL: if (!i_ack) w_next = O_IDLE;
      default: w_next = O_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= O_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_pakio <= '0;
    end else begin
      r_state <= w_next;
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      // A push and pop in the same cycle leave the occupancy unchanged.
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_load) r_pakio <= r_mem[r_rptr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_pkt;
  end

`ifdef NS_PAKOUT_ROUTER_CNT_EN
  logic [7:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)      r_cnt <= '0;
    else if (w_pop) r_cnt <= r_cnt + 8'd1;
  end

  assign o_cnt = r_cnt;
`endif

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_req   = (r_state == O_REQ);
  assign o_pakio = r_pakio;

endmodule

// File: rtl/pakout_router.sv
// Routes packets from one inbound req/ack channel to NCH buffered outbound channels
// by destination address. NS_PAKOUT_ROUTER_CNT_EN adds per-channel snd_cnt counters.
module pakout_router
  import pakout_router_pkg::*;
#(
  parameter int PSZ       = NS_PACKET_SIZE,
  parameter int ASZ       = NS_ADDRESS_SIZE,
  parameter int DSZ       = NS_DATA_SIZE,
  parameter int NCH       = 4,
  parameter int DEPTH     = 4,
  parameter int ADDR_SPAN = 16
) (
  input  logic               i_clk,
  input  logic               reset,
  output logic               ready,
  input  logic               rcv0_req,
  output logic               rcv0_ack,
  input  logic [PSZ-1:0]     rcv0_pakio,
  output logic [NCH-1:0]     snd_req,
  input  logic [NCH-1:0]     snd_ack,
  output logic [NCH*PSZ-1:0] snd_pakio,
`ifdef NS_PAKOUT_ROUTER_CNT_EN
  output logic [NCH*8-1:0]   snd_cnt,
`endif
  output logic               err,
  output logic [ASZ-1:0]     err_addr
);

  localparam int IW = $clog2(NCH);

  in_state_t      r_in_state;
  in_state_t      w_in_next;
  logic           r_live;
  logic           r_err;
  logic [ASZ-1:0] r_err_addr;
  logic [ASZ-1:0] w_dst;
  logic [PSZ-1:0] w_pkt;
  int             w_idx;
  logic [IW-1:0]  w_sel;
  logic           w_in_range;
  logic           w_accept;
  logic           w_drop;
  logic [NCH-1:0] w_push;
  logic [NCH-1:0] w_full;
  logic [NCH-1:0] w_empty;

  assign w_dst      = rcv0_pakio[PSZ-1 -: ASZ];
  assign w_pkt      = {rcv0_pakio[PSZ-1:DSZ], rcv0_pakio[DSZ-1:0]};
  assign w_idx      = route_idx(int'(32'(w_dst)), ADDR_SPAN);
  assign w_in_range = (w_idx < NCH);
  assign w_sel      = IW'(w_idx);

  // Out-of-range packets are acknowledged and discarded so the source never hangs.
  always_comb begin
    w_in_next = r_in_state;
    w_accept  = 1'b0;
    w_drop    = 1'b0;
    case (r_in_state)
      IN_IDLE: if (rcv0_req) begin
        if (!w_in_range) begin
          w_drop    = 1'b1;
          w_in_next = IN_WAIT;
        end else if (!w_full[w_sel]) begin
          w_accept  = 1'b1;
          w_in_next = IN_WAIT;
        end
      end
      IN_WAIT: if (!rcv0_req) w_in_next = IN_IDLE;
      default: w_in_next = IN_IDLE;
    endcase
  end

  always_comb begin
    w_push = '0;
    for (int k = 0; k < NCH; k++) w_push[k] = w_accept && (w_sel == IW'(k));
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_in_state <= IN_IDLE;
      r_live     <= 1'b0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_in_state <= w_in_next;
      r_live     <= 1'b1;
      if (w_drop && !r_err) begin
        r_err      <= 1'b1;
        r_err_addr <= w_dst;
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chnl
    pakout_router_chnl #(
      .PSZ   (PSZ),
      .DEPTH (DEPTH)
    ) u_chnl (
      .i_clk   (i_clk),
      .i_rst   (reset),
      .i_push  (w_push[k]),
      .i_pkt   (w_pkt),
      .o_full  (w_full[k]),
      .o_empty (w_empty[k]),
      .o_req   (snd_req[k]),
      .i_ack   (snd_ack[k]),
      .o_pakio (snd_pakio[k*PSZ +: PSZ])
`ifdef NS_PAKOUT_ROUTER_CNT_EN
      ,
      .o_cnt   (snd_cnt[k*8 +: 8])
`endif
    );
  end

  assign rcv0_ack = (r_in_state == IN_WAIT);
  assign ready    = r_live && (&w_empty);
  assign err      = r_err;
  assign err_addr = r_err_addr;

endmodule

// File: tb/tb_pakout_router.sv
// Directed bench for pakout_router (NCH=4, DEPTH=4, ADDR_SPAN=16, 32-bit packets
// with an 8-bit destination in the top byte).
module tb_pakout_router;

  localparam int PSZ = 32;
  localparam int NCH = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               ready;
  logic               rcv0_req = 1'b0;
  logic               rcv0_ack;
  logic [PSZ-1:0]     rcv0_pakio = '0;
  logic [NCH-1:0]     snd_req;
  logic [NCH-1:0]     snd_ack = '0;
  logic [NCH*PSZ-1:0] snd_pakio;
  logic               err;
  logic [7:0]         err_addr;
`ifdef NS_PAKOUT_ROUTER_CNT_EN
  logic [NCH*8-1:0]   snd_cnt;
`endif

  int total = 0;
  int bad = 0;

  logic [PSZ-1:0] rxq [NCH][$];
  int             rise_cnt [NCH] = '{default: 0};
  logic [NCH-1:0] prev_req = '0;
  logic [NCH-1:0] sink_en = '1;

  always #5 clk = ~clk;

  pakout_router dut (
    .i_clk      (clk),
    .reset      (reset),
    .ready      (ready),
    .rcv0_req   (rcv0_req),
    .rcv0_ack   (rcv0_ack),
    .rcv0_pakio (rcv0_pakio),
    .snd_req    (snd_req),
    .snd_ack    (snd_ack),
    .snd_pakio  (snd_pakio),
`ifdef NS_PAKOUT_ROUTER_CNT_EN
    .snd_cnt    (snd_cnt),
`endif
    .err        (err),
    .err_addr   (err_addr)
  );

  // Four-phase sink model per channel; logs every packet it acknowledges.
  always @(negedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (snd_req[k] && !prev_req[k]) rise_cnt[k]++;
      prev_req[k] = snd_req[k];
      if (!sink_en[k]) snd_ack[k] = 1'b0;
      else if (snd_req[k] && !snd_ack[k]) begin
        rxq[k].push_back(snd_pakio[k*PSZ +: PSZ]);
        snd_ack[k] = 1'b1;
      end else if (!snd_req[k]) snd_ack[k] = 1'b0;
    end
  end

  function automatic logic [PSZ-1:0] mk(input logic [7:0] dst, input logic [15:0] dat);
    return {dst, 8'hA5, dat};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PSZ-1:0] p, output bit ok);
    int n;
    ok = 1'b1;
    rcv0_pakio = p;
    rcv0_req = 1'b1;
    n = 0;
    while (rcv0_ack !== 1'b1 && n < 40) begin tick(); n++; end
    if (rcv0_ack !== 1'b1) ok = 1'b0;
    rcv0_req = 1'b0;
    n = 0;
    while (rcv0_ack !== 1'b0 && n < 40) begin tick(); n++; end
    if (rcv0_ack !== 1'b0) ok = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin tick(); n++; end
    ok = (ready === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rcv0_req = 1'b0;
    sink_en = '1;
    repeat (3) tick();
    total++; if (rcv0_ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", rcv0_ack); end
    total++; if (snd_req !== 4'b0000) begin bad++; $display("FAIL rst_req: got %b want 0000", snd_req); end
    total++; if (snd_pakio !== '0) begin bad++; $display("FAIL rst_pakio: got %h want 0", snd_pakio); end
    total++; if (err !== 1'b0 || err_addr !== 8'h00) begin bad++; $display("FAIL rst_err: got %b/%h want 0/00", err, err_addr); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", ready); end
    reset = 1'b0;
    tick();
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rise: got %b want 1", ready); end
  endtask

  task automatic test_single();
    logic [PSZ-1:0] p;
    int b0;
    int rb [NCH];
    bit ok;
    b0 = rxq[0].size();
    for (int k = 0; k < NCH; k++) rb[k] = rise_cnt[k];
    p = mk(8'd5, 16'h003C);
    rcv0_pakio = p;
    rcv0_req = 1'b1;
    tick();
    total++; if (rcv0_ack !== 1'b1) begin bad++; $display("FAIL single_ack: got %b want 1", rcv0_ack); end
    total++; if (snd_req !== 4'b0000) begin bad++; $display("FAIL single_req_early: got %b want 0000", snd_req); end
    tick();
    total++; if (snd_req !== 4'b0001) begin bad++; $display("FAIL single_req: got %b want 0001", snd_req); end
    total++; if (snd_pakio[31:0] !== p) begin bad++; $display("FAIL single_pakio: got %h want %h", snd_pakio[31:0], p); end
    rcv0_req = 1'b0;
    wait_ready(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_ready: got %b want 1", ready); end
    tick();
    total++; if (rcv0_ack !== 1'b0) begin bad++; $display("FAIL single_ack_clr: got %b want 0", rcv0_ack); end
    total++; if (rxq[0].size() != b0 + 1) begin bad++; $display("FAIL single_count: got %0d want %0d", rxq[0].size() - b0, 1); end
    else begin
      total++; if (rxq[0][b0] !== p) begin bad++; $display("FAIL single_data: got %h want %h", rxq[0][b0], p); end
    end
    for (int k = 1; k < NCH; k++) begin
      total++; if (rise_cnt[k] != rb[k]) begin bad++; $display("FAIL single_idle_ch%0d: got %0d want 0 req rises", k, rise_cnt[k] - rb[k]); end
    end
  endtask

  task automatic test_routing();
    logic [7:0] dsts [3];
    int b [NCH];
    bit ok;
    dsts = '{8'd17, 8'd33, 8'd49};
    for (int k = 0; k < NCH; k++) b[k] = rxq[k].size();
    for (int i = 0; i < 3; i++) begin
      send(mk(dsts[i], 16'h1100 + 16'(i)), ok);
      total++; if (!ok) begin bad++; $display("FAIL route_send%0d: got timeout want ack", i); end
    end
    wait_ready(ok);
    total++; if (!ok) begin bad++; $display("FAIL route_ready: got %b want 1", ready); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rxq[i+1].size() != b[i+1] + 1 || rxq[i+1][b[i+1]] !== mk(dsts[i], 16'h1100 + 16'(i))) begin
        bad++;
        $display("FAIL route_ch%0d: got %0d pkts want 1 pkt %h", i + 1, rxq[i+1].size() - b[i+1], mk(dsts[i], 16'h1100 + 16'(i)));
      end
    end
    total++; if (rxq[0].size() != b[0]) begin bad++; $display("FAIL route_ch0: got %0d pkts want 0", rxq[0].size() - b[0]); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL route_err: got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    int b0, b2;
    bit ok;
    b0 = rxq[0].size();
    b2 = rxq[2].size();
    sink_en[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(mk(8'd40, 16'h2000 + 16'(i)), ok);
      total++; if (!ok) begin bad++; $display("FAIL bp_accept%0d: got timeout want ack", i); end
    end
    rcv0_pakio = mk(8'd40, 16'h2004);
    rcv0_req = 1'b1;
    repeat (10) tick();
    total++; if (rcv0_ack !== 1'b0) begin bad++; $display("FAIL bp_stall: got %b want 0", rcv0_ack); end
    total++; if (snd_req[2] !== 1'b1 || snd_pakio[95:64] !== mk(8'd40, 16'h2000)) begin
      bad++; $display("FAIL bp_head: got %b/%h want 1/%h", snd_req[2], snd_pakio[95:64], mk(8'd40, 16'h2000));
    end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL bp_ready: got %b want 0", ready); end
    sink_en[2] = 1'b1;
    send(mk(8'd40, 16'h2004), ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_release: got timeout want ack"); end
    send(mk(8'd3, 16'h0333), ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_hol_send: got timeout want ack"); end
    wait_ready(ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_ready_end: got %b want 1", ready); end
    total++; if (rxq[2].size() != b2 + 5) begin bad++; $display("FAIL bp_count: got %0d want 5", rxq[2].size() - b2); end
    else begin
      for (int i = 0; i < 5; i++) begin
        total++; if (rxq[2][b2+i] !== mk(8'd40, 16'h2000 + 16'(i))) begin
          bad++; $display("FAIL bp_order%0d: got %h want %h", i, rxq[2][b2+i], mk(8'd40, 16'h2000 + 16'(i)));
        end
      end
    end
    total++; if (rxq[0].size() != b0 + 1 || rxq[0][b0] !== mk(8'd3, 16'h0333)) begin
      bad++; $display("FAIL bp_hol_data: got %0d pkts want 1 pkt %h", rxq[0].size() - b0, mk(8'd3, 16'h0333));
    end
  endtask

  task automatic test_error();
    int rb [NCH];
    int d;
    bit ok1, ok2;
    for (int k = 0; k < NCH; k++) rb[k] = rise_cnt[k];
    send(mk(8'd70, 16'h7070), ok1);
    send(mk(8'd90, 16'h9090), ok2);
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL err_acked: got %b%b want 11", ok1, ok2); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_flag: got %b want 1", err); end
    total++; if (err_addr !== 8'd70) begin bad++; $display("FAIL err_addr: got %0d want 70", err_addr); end
    repeat (5) tick();
    d = 0;
    for (int k = 0; k < NCH; k++) d += rise_cnt[k] - rb[k];
    total++; if (d != 0) begin bad++; $display("FAIL err_no_req: got %0d req rises want 0", d); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL err_ready: got %b want 1", ready); end
  endtask

  task automatic test_reset_mid();
    int b1, r1;
    bit ok1, ok2;
    sink_en[1] = 1'b0;
    send(mk(8'd20, 16'hAAAA), ok1);
    send(mk(8'd21, 16'hBBBB), ok2);
    tick();
    total++; if (!(ok1 && ok2) || snd_req[1] !== 1'b1) begin bad++; $display("FAIL mid_setup: got ok=%b%b req=%b want 11/1", ok1, ok2, snd_req[1]); end
    reset = 1'b1;
    tick();
    total++; if (snd_req !== 4'b0000) begin bad++; $display("FAIL mid_req: got %b want 0000", snd_req); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got %b want 0", ready); end
    total++; if (err !== 1'b0 || err_addr !== 8'h00) begin bad++; $display("FAIL mid_err_clr: got %b/%h want 0/00", err, err_addr); end
    reset = 1'b0;
    b1 = rxq[1].size();
    r1 = rise_cnt[1];
    sink_en[1] = 1'b1;
    repeat (20) tick();
    total++; if (rxq[1].size() != b1 || rise_cnt[1] != r1) begin
      bad++; $display("FAIL mid_lost: got %0d pkts %0d rises want 0/0", rxq[1].size() - b1, rise_cnt[1] - r1);
    end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL mid_ready_back: got %b want 1", ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] dsts [5];
    int         chs  [5];
    int b [NCH];
    bit ok;
    dsts = '{8'd0, 8'd15, 8'd16, 8'd63, 8'd1};
    chs  = '{0, 0, 1, 3, 0};
    for (int k = 0; k < NCH; k++) b[k] = rxq[k].size();
    for (int i = 0; i < 5; i++) begin
      send(mk(dsts[i], 16'h5000 + 16'(i)), ok);
      total++; if (!ok) begin bad++; $display("FAIL b2b_send%0d: got timeout want ack", i); end
    end
    wait_ready(ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_ready: got %b want 1", ready); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rxq[chs[i]].size() <= b[chs[i]] || rxq[chs[i]][b[chs[i]]] !== mk(dsts[i], 16'h5000 + 16'(i))) begin
        bad++; $display("FAIL b2b_route%0d: got ch%0d missing/wrong want %h", i, chs[i], mk(dsts[i], 16'h5000 + 16'(i)));
      end else b[chs[i]]++;
    end
    send(mk(8'd64, 16'h6464), ok);
    send(mk(8'd255, 16'hFFFF), ok);
    total++; if (err !== 1'b1 || err_addr !== 8'd64) begin bad++; $display("FAIL b2b_err64: got %b/%0d want 1/64", err, err_addr); end
  endtask

`ifdef NS_PAKOUT_ROUTER_CNT_EN
  task automatic test_counter();
    bit ok;
    int fails;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    fails = 0;
    for (int i = 0; i < 260; i++) begin
      send(mk(8'd2, 16'(i)), ok);
      if (!ok) fails++;
    end
    wait_ready(ok);
    total++; if (fails != 0 || !ok) begin bad++; $display("FAIL cnt_send: got %0d timeouts want 0", fails); end
    total++; if (snd_cnt[7:0] !== 8'd4) begin bad++; $display("FAIL cnt_ch0: got %0d want 4", snd_cnt[7:0]); end
    total++; if (snd_cnt[31:8] !== 24'h0) begin bad++; $display("FAIL cnt_others: got %h want 000000", snd_cnt[31:8]); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_routing();
    test_backpressure();
    test_error();
    test_reset_mid();
    test_back_to_back();
`ifdef NS_PAKOUT_ROUTER_CNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
